// File: rtl/mul_operand_issuer.sv
// mul_operand_issuer
//   Buffers operand pairs in a small FIFO and issues them one at a time to an
//   add-shift multiplier. It holds mul_a/mul_b stable and pulses mul_start for
//   one cycle, then waits for mul_done. Each product is returned on a
//   valid/ready port together with its operands and a 4-bit sequence tag.
//
// Ports
//   clk, rst               : clock, synchronous active-high reset
//   in_valid/in_ready      : producer handshake, operands in_a/in_b
//   mul_a/mul_b/mul_start  : operands and start pulse to the multiplier
//   mul_done/mul_prod      : completion pulse and product from the multiplier
//   out_valid/out_ready    : consumer handshake, out_prod/out_a/out_b/out_tag
//   busy                   : controller is not idle
module mul_operand_issuer #(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned DEPTH = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    input  logic [WIDTH-1:0]   in_a,
    input  logic [WIDTH-1:0]   in_b,
    output logic               in_ready,
    output logic [WIDTH-1:0]   mul_a,
    output logic [WIDTH-1:0]   mul_b,
    output logic               mul_start,
    input  logic               mul_done,
    input  logic [2*WIDTH-1:0] mul_prod,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] out_prod,
    output logic [WIDTH-1:0]   out_a,
    output logic [WIDTH-1:0]   out_b,
    output logic [3:0]         out_tag,
    output logic               busy
);

    localparam int unsigned PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW    = $clog2(DEPTH + 1);
    localparam int unsigned PRODW = 2 * WIDTH;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        HOLD  = 2'd3
    } state_t;

    state_t            state_q;
    state_t            state_d;
    logic [PW-1:0]     wr_ptr;
    logic [PW-1:0]     rd_ptr;
    logic [CW-1:0]     count;
    logic [CW-1:0]     count_d;
    logic [WIDTH-1:0]  mem_a [DEPTH];
    logic [WIDTH-1:0]  mem_b [DEPTH];

    logic push_c;
    logic pop_c;
    logic capture_c;
    logic accept_c;

    // Next-state and datapath enables
    always_comb begin
        state_d   = state_q;
        push_c    = in_valid & in_ready;
        pop_c     = 1'b0;
        capture_c = 1'b0;
        accept_c  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (count != CW'(0)) begin
                    pop_c   = 1'b1;
                    state_d = ISSUE;
                end
            end
            ISSUE: state_d = WAIT;
            WAIT: begin
                if (mul_done) begin
                    capture_c = 1'b1;
                    state_d   = HOLD;
                end
            end
            HOLD: begin
                if (out_ready) begin
                    accept_c = 1'b1;
                    state_d  = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Occupancy after this edge; simultaneous push and pop cancel
    always_comb begin
        count_d = count;
        unique case ({push_c, pop_c})
            2'b10:   count_d = CW'(count + CW'(1));
            2'b01:   count_d = CW'(count - CW'(1));
            default: count_d = count;
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Pointers, count, operand/result registers and registered status outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            mul_a     <= '0;
            mul_b     <= '0;
            mul_start <= 1'b0;
            out_valid <= 1'b0;
            out_prod  <= '0;
            out_a     <= '0;
            out_b     <= '0;
            out_tag   <= '0;
            busy      <= 1'b0;
            in_ready  <= 1'b1;
        end else begin
            count <= count_d;
            if (push_c) begin
                wr_ptr <= PW'(wr_ptr + PW'(1));
            end
            if (pop_c) begin
                mul_a  <= mem_a[rd_ptr];
                mul_b  <= mem_b[rd_ptr];
                rd_ptr <= PW'(rd_ptr + PW'(1));
            end
            if (capture_c) begin
                out_prod <= PRODW'(mul_prod);
                out_a    <= mul_a;
                out_b    <= mul_b;
            end
            if (accept_c) begin
                out_tag <= 4'(out_tag + 4'd1);
            end
            // Status flags track the state/count they will describe after this edge
            mul_start <= (state_d == ISSUE);
            out_valid <= (state_d == HOLD);
            busy      <= (state_d != IDLE);
            in_ready  <= (count_d != CW'(DEPTH));
        end
    end

    // FIFO storage; contents need no reset since count gates every read
    always_ff @(posedge clk) begin
        if (push_c) begin
            mem_a[wr_ptr] <= in_a;
            mem_b[wr_ptr] <= in_b;
        end
    end

endmodule

// File: tb/tb_mul_operand_issuer.sv
module tb_mul_operand_issuer;

    localparam int unsigned WIDTH = 4;
    localparam int unsigned PRODW = 2 * WIDTH;
    localparam int unsigned LAT   = 3;

    logic             clk;
    logic             rst;
    logic             in_valid;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic             in_ready;
    logic [WIDTH-1:0] mul_a;
    logic [WIDTH-1:0] mul_b;
    logic             mul_start;
    logic             mul_done;
    logic [PRODW-1:0] mul_prod;
    logic             out_valid;
    logic             out_ready;
    logic [PRODW-1:0] out_prod;
    logic [WIDTH-1:0] out_a;
    logic [WIDTH-1:0] out_b;
    logic [3:0]       out_tag;
    logic             busy;

    int n_checks = 0;
    int n_fail   = 0;

    mul_operand_issuer #(.WIDTH(WIDTH), .DEPTH(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_ready  (in_ready),
        .mul_a     (mul_a),
        .mul_b     (mul_b),
        .mul_start (mul_start),
        .mul_done  (mul_done),
        .mul_prod  (mul_prod),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_prod  (out_prod),
        .out_a     (out_a),
        .out_b     (out_b),
        .out_tag   (out_tag),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Multiplier stand-in: fixed latency after the start pulse; a stray pulse
    // carries a garbage product so any wrongful capture is visible.
    logic             model_done;
    logic [PRODW-1:0] model_prod;
    logic             stray;
    int               model_cnt;
    assign mul_done = model_done | stray;
    assign mul_prod = model_done ? model_prod : 8'hFF;

    always @(posedge clk) begin
        if (rst) begin
            model_cnt  <= 0;
            model_done <= 1'b0;
            model_prod <= '0;
        end else begin
            model_done <= 1'b0;
            if (mul_start) begin
                model_cnt <= LAT;
            end else if (model_cnt != 0) begin
                model_cnt <= model_cnt - 1;
                if (model_cnt == 1) begin
                    model_done <= 1'b1;
                    model_prod <= PRODW'(mul_a) * PRODW'(mul_b);
                end
            end
        end
    end

    // Start-pulse monitor
    int               starts = 0;
    int               back_to_back = 0;
    logic             prev_start = 1'b0;
    logic [WIDTH-1:0] start_a = '0;
    logic [WIDTH-1:0] start_b = '0;
    always @(posedge clk) begin
        prev_start <= mul_start;
        if (mul_start) begin
            starts  <= starts + 1;
            start_a <= mul_a;
            start_b <= mul_b;
            if (prev_start) back_to_back <= back_to_back + 1;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        in_valid = 1'b1;
        in_a     = a;
        in_b     = b;
        check("push_in_ready", 32'(in_ready), 32'd1);
        step();
        in_valid = 1'b0;
    endtask

    task automatic wait_valid(input string tag);
        int n;
        n = 0;
        while (!out_valid && n < 40) begin
            step();
            n++;
        end
        if (!out_valid) begin
            n_checks++;
            n_fail++;
            $error("FAIL %s: out_valid observed 0 after %0d cycles, expected 1", tag, n);
        end
    endtask

    task automatic check_result(input logic [PRODW-1:0] p, input logic [WIDTH-1:0] a,
                                input logic [WIDTH-1:0] b, input logic [3:0] t);
        check("out_prod", 32'(out_prod), 32'(p));
        check("out_a",    32'(out_a),    32'(a));
        check("out_b",    32'(out_b),    32'(b));
        check("out_tag",  32'(out_tag),  32'(t));
    endtask

    task automatic accept();
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check("out_valid_after_accept", 32'(out_valid), 32'd0);
    endtask

    int s0;

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_a      = '0;
        in_b      = '0;
        out_ready = 1'b0;
        stray     = 1'b0;
        step();
        step();
        rst = 1'b0;

        // Reset values
        check("rst_in_ready",  32'(in_ready),  32'd1);
        check("rst_busy",      32'(busy),      32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_mul_start", 32'(mul_start), 32'd0);
        check("rst_out_tag",   32'(out_tag),   32'd0);
        check("rst_mul_a",     32'(mul_a),     32'd0);
        check("rst_out_prod",  32'(out_prod),  32'd0);

        // Single operation 6*6
        push(4'd6, 4'd6);
        wait_valid("t1_valid");
        check_result(8'd36, 4'd6, 4'd6, 4'd0);
        check("t1_starts",  32'(starts),  32'd1);
        check("t1_start_a", 32'(start_a), 32'd6);
        check("t1_start_b", 32'(start_b), 32'd6);

        // Fill the FIFO while the previous result is held unaccepted
        push(4'd2, 4'd6);
        push(4'd7, 4'd5);
        push(4'd7, 4'd7);
        push(4'd5, 4'd5);
        in_valid = 1'b1;
        in_a     = 4'd1;
        in_b     = 4'd1;
        check("t2_full_in_ready", 32'(in_ready), 32'd0);
        step();
        in_valid = 1'b0;
        check("t2_hold_out_prod", 32'(out_prod), 32'd36);
        accept();
        check("t1_busy_after_accept", 32'(busy), 32'd0);
        check("t2_no_extra_start", 32'(starts), 32'd1);

        wait_valid("t2_r0");
        check_result(8'd12, 4'd2, 4'd6, 4'd1);
        accept();
        wait_valid("t2_r1");
        check_result(8'd35, 4'd7, 4'd5, 4'd2);
        accept();
        wait_valid("t2_r2");
        check_result(8'd49, 4'd7, 4'd7, 4'd3);
        accept();
        wait_valid("t2_r3");
        check_result(8'd25, 4'd5, 4'd5, 4'd4);
        accept();

        // Back-pressure with a queued operation
        push(4'd7, 4'd3);
        push(4'd4, 4'd6);
        wait_valid("t3_r0");
        check_result(8'd21, 4'd7, 4'd3, 4'd5);
        s0 = starts;
        for (int i = 0; i < 10; i++) begin
            step();
            check("t3_hold_valid", 32'(out_valid), 32'd1);
            check("t3_hold_prod",  32'(out_prod),  32'd21);
        end
        check("t3_no_start_in_hold", 32'(starts), 32'(s0));
        accept();
        wait_valid("t3_r1");
        check_result(8'd24, 4'd4, 4'd6, 4'd6);
        accept();
        step();
        step();

        // Stray done in IDLE
        s0 = starts;
        stray = 1'b1;
        step();
        stray = 1'b0;
        check("t4_idle_valid", 32'(out_valid), 32'd0);
        check("t4_idle_busy",  32'(busy),      32'd0);
        step();
        check("t4_idle_valid2", 32'(out_valid), 32'd0);
        check("t4_idle_starts", 32'(starts),    32'(s0));

        // Stray done during ISSUE
        push(4'd3, 4'd2);
        step();
        check("t4_issue_start", 32'(mul_start), 32'd1);
        stray = 1'b1;
        step();
        stray = 1'b0;
        check("t4_issue_valid", 32'(out_valid), 32'd0);
        check("t4_issue_busy",  32'(busy),      32'd1);
        check("t4_issue_start_low", 32'(mul_start), 32'd0);
        wait_valid("t4_r0");
        check_result(8'd6, 4'd3, 4'd2, 4'd7);
        accept();

        // Reset during WAIT with two entries queued
        push(4'd5, 4'd3);
        push(4'd2, 4'd2);
        push(4'd3, 4'd3);
        check("t5_wait_busy", 32'(busy), 32'd1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("t5_in_ready",  32'(in_ready),  32'd1);
        check("t5_out_valid", 32'(out_valid), 32'd0);
        check("t5_out_tag",   32'(out_tag),   32'd0);
        check("t5_busy",      32'(busy),      32'd0);
        check("t5_mul_a",     32'(mul_a),     32'd0);
        s0 = starts;
        for (int i = 0; i < 10; i++) step();
        check("t5_no_start", 32'(starts),    32'(s0));
        check("t5_no_valid", 32'(out_valid), 32'd0);
        check("t5_idle",     32'(busy),      32'd0);

        // Tag wrap over 17 results
        for (int i = 0; i < 17; i++) begin
            push(4'd15, 4'd15);
            wait_valid("t6_valid");
            check_result(8'd225, 4'd15, 4'd15, 4'(i % 16));
            accept();
        end

        check("no_back_to_back_start", 32'(back_to_back), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
